// File: rtl/countdown_ctrl.sv
// Countdown controller: launches a requested number of runs on an external down-counter
// and polices the start/ready handshake, the per-cycle step and each run's duration.
module countdown_ctrl #(
  parameter int unsigned TIMEOUT = 40,
  parameter int unsigned ACK_MAX = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       go,
  input  logic [3:0] runs,
  input  logic       clr,
  input  logic       cnt_ready,
  input  logic [4:0] cnt_q,
  output logic       cnt_start,
  output logic       busy,
  output logic       done,
  output logic [3:0] runs_done,
  output logic       err,
  output logic [1:0] err_code
);

  localparam int unsigned WdW  = $clog2(TIMEOUT + 1);
  localparam int unsigned AckW = $clog2(ACK_MAX + 1);
  localparam logic [WdW-1:0]  WdLast  = WdW'(TIMEOUT - 1);
  localparam logic [AckW-1:0] AckLast = AckW'(ACK_MAX - 1);

  localparam logic [1:0] CodeNoAck   = 2'd1;
  localparam logic [1:0] CodeSeq     = 2'd2;
  localparam logic [1:0] CodeTimeout = 2'd3;

  typedef enum logic [2:0] {StIdle, StLaunch, StWaitAck, StRun, StErr} state_e;

  state_e          state;
  logic [3:0]      runs_cap;
  logic [4:0]      prev_q;
  logic [WdW-1:0]  wdog;
  logic [AckW-1:0] ack_cnt;

  logic            step_ok;
  logic            wd_hit;
  logic [3:0]      rd_next;
  logic [1:0]      fault;

  // Fault detection per state; a sequence error outranks a watchdog expiry.
  always_comb begin
    step_ok = (prev_q != 5'd0) && (cnt_q == prev_q - 5'd1);
    wd_hit  = (wdog == WdLast);
    rd_next = (runs_done == 4'hF) ? 4'hF : runs_done + 4'd1;
    fault   = 2'd0;
    case (state)
      StLaunch: begin
        if (wd_hit) fault = CodeTimeout;
      end
      StWaitAck: begin
        if (cnt_ready && (ack_cnt == AckLast)) fault = CodeNoAck;
        else if (wd_hit)                       fault = CodeTimeout;
      end
      StRun: begin
        if (cnt_ready ? (cnt_q != 5'd0) : !step_ok) fault = CodeSeq;
        else if (wd_hit)                            fault = CodeTimeout;
      end
      default: fault = 2'd0;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= StIdle;
      cnt_start <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      runs_done <= 4'd0;
      err       <= 1'b0;
      err_code  <= 2'd0;
      runs_cap  <= 4'd0;
      prev_q    <= 5'd0;
      wdog      <= '0;
      ack_cnt   <= '0;
    end else begin
      cnt_start <= 1'b0;
      done      <= 1'b0;
      if (clr) begin
        state    <= StIdle;
        busy     <= 1'b0;
        err      <= 1'b0;
        err_code <= 2'd0;
        wdog     <= '0;
        ack_cnt  <= '0;
      end else if (fault != 2'd0) begin
        state    <= StErr;
        busy     <= 1'b0;
        err      <= 1'b1;
        err_code <= fault;
      end else begin
        case (state)
          StIdle: begin
            // A go during the done pulse is ignored so commands never overlap.
            if (go && cnt_ready && !done) begin
              runs_done <= 4'd0;
              if (runs == 4'd0) begin
                done <= 1'b1;
              end else begin
                runs_cap  <= runs;
                cnt_start <= 1'b1;
                busy      <= 1'b1;
                wdog      <= '0;
                state     <= StLaunch;
              end
            end
          end
          StLaunch: begin
            wdog    <= wdog + WdW'(1);
            ack_cnt <= '0;
            state   <= StWaitAck;
          end
          StWaitAck: begin
            wdog <= wdog + WdW'(1);
            if (!cnt_ready) begin
              prev_q <= cnt_q;
              state  <= StRun;
            end else begin
              ack_cnt <= ack_cnt + AckW'(1);
            end
          end
          StRun: begin
            if (cnt_ready) begin
              runs_done <= rd_next;
              if (rd_next == runs_cap) begin
                done  <= 1'b1;
                busy  <= 1'b0;
                state <= StIdle;
              end else begin
                cnt_start <= 1'b1;
                wdog      <= '0;
                state     <= StLaunch;
              end
            end else begin
              prev_q <= cnt_q;
              wdog   <= wdog + WdW'(1);
            end
          end
          StErr:   state <= StErr;
          default: state <= StIdle;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_countdown_ctrl.sv
// Bench for countdown_ctrl: two instances (default and short watchdog), each driving a
// behavioural down-counter that can misbehave on request.
module tb_countdown_ctrl;

  localparam int TMO = 10;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] go;
  logic [3:0] runs;
  logic       clr;

  logic [1:0] cs, bz, dn, er;
  logic [1:0] code0, code1;
  logic [3:0] rd0, rd1;

  logic [1:0] c_ready;
  logic [4:0] c_q [2];
  int         c_mode [2];  // 0 ok, 1 never acks, 2 skips 20->18, 3 ready early at q=10
  logic [4:0] c_load [2];

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  countdown_ctrl dut0 (
    .clk(clk), .rst(rst), .go(go[0]), .runs(runs), .clr(clr),
    .cnt_ready(c_ready[0]), .cnt_q(c_q[0]), .cnt_start(cs[0]), .busy(bz[0]),
    .done(dn[0]), .runs_done(rd0), .err(er[0]), .err_code(code0)
  );

  countdown_ctrl #(.TIMEOUT(TMO)) dut1 (
    .clk(clk), .rst(rst), .go(go[1]), .runs(runs), .clr(clr),
    .cnt_ready(c_ready[1]), .cnt_q(c_q[1]), .cnt_start(cs[1]), .busy(bz[1]),
    .done(dn[1]), .runs_done(rd1), .err(er[1]), .err_code(code1)
  );

  always @(posedge clk or negedge rst) begin
    for (int i = 0; i < 2; i++) begin
      if (!rst) begin
        c_ready[i] <= 1'b1;
        c_q[i]     <= 5'd0;
      end else if (c_ready[i]) begin
        if (cs[i] && c_mode[i] != 1) begin
          c_ready[i] <= 1'b0;
          c_q[i]     <= c_load[i];
        end
      end else if (c_mode[i] == 3 && c_q[i] == 5'd10) begin
        c_ready[i] <= 1'b1;
      end else if (c_mode[i] == 2 && c_q[i] == 5'd20) begin
        c_q[i] <= 5'd18;
      end else if (c_q[i] == 5'd1) begin
        c_q[i]     <= 5'd0;
        c_ready[i] <= 1'b1;
      end else begin
        c_q[i] <= c_q[i] - 5'd1;
      end
    end
  end

  typedef struct {
    logic [3:0] runs;
    logic       with_clr;
    int         mode;
    logic [4:0] load;
    int         starts;
    int         dones;
    logic [3:0] rd;
    logic [1:0] code;
  } vec_t;

  function automatic logic [9:0] outs(input int i);
    if (i == 0) return {cs[0], bz[0], dn[0], er[0], code0, rd0};
    return {cs[1], bz[1], dn[1], er[1], code1, rd1};
  endfunction

  // Expected outputs of the TMO instance c cycles after a go, against a compliant counter
  // loaded with L: every run lasts p = L+2 cycles, and a run of TMO cycles or more times out.
  function automatic logic [9:0] expect_at(input int c, input int n, input int p, input bit tmo);
    logic cs_e, bz_e, dn_e, er_e;
    logic [1:0] cd_e;
    int rd_e;
    cs_e = 1'b0; bz_e = 1'b0; dn_e = 1'b0; er_e = 1'b0; cd_e = 2'd0; rd_e = 0;
    if (n == 0) begin
      dn_e = (c == 1);
    end else if (tmo) begin
      cs_e = (c == 1);
      bz_e = (c <= TMO);
      er_e = (c > TMO);
      cd_e = er_e ? 2'd3 : 2'd0;
    end else begin
      cs_e = (c <= n * p) && ((c - 1) % p == 0);
      bz_e = (c <= n * p);
      dn_e = (c == n * p + 1);
      rd_e = (c - 1) / p;
      if (rd_e > n) rd_e = n;
    end
    return {cs_e, bz_e, dn_e, er_e, cd_e, 4'(rd_e)};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic skip(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_idle(input int i);
    bit ok;
    ok = 1'b0;
    for (int k = 0; k < 100 && !ok; k++) begin
      if (c_ready[i] && !bz[i] && !dn[i]) ok = 1'b1;
      else @(negedge clk);
    end
    if (!ok) begin
      n_cmp++;
      n_bad++;
      $display("FAIL wait_idle%0d: got busy after 100 cycles, expected idle", i);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL sim_timeout: got still running, expected finished");
    $fatal(1, "simulation time limit");
  end

  initial begin
    vec_t vt [9];
    int nst, ndn, nbz, L, n, P, m, last;
    bit tmo, abort;
    logic [9:0] ex;
    logic [3:0] rd_m;

    vt[0] = '{runs:4'd2,  with_clr:1'b0, mode:0, load:5'd31, starts:2,  dones:1, rd:4'd2,  code:2'd0};
    vt[1] = '{runs:4'd2,  with_clr:1'b1, mode:0, load:5'd31, starts:0,  dones:0, rd:4'd2,  code:2'd0};
    vt[2] = '{runs:4'd0,  with_clr:1'b0, mode:0, load:5'd31, starts:0,  dones:1, rd:4'd0,  code:2'd0};
    vt[3] = '{runs:4'd1,  with_clr:1'b0, mode:1, load:5'd31, starts:1,  dones:0, rd:4'd0,  code:2'd1};
    vt[4] = '{runs:4'd1,  with_clr:1'b0, mode:2, load:5'd31, starts:1,  dones:0, rd:4'd0,  code:2'd2};
    vt[5] = '{runs:4'd3,  with_clr:1'b0, mode:3, load:5'd31, starts:1,  dones:0, rd:4'd0,  code:2'd2};
    vt[6] = '{runs:4'd15, with_clr:1'b0, mode:0, load:5'd1,  starts:15, dones:1, rd:4'd15, code:2'd0};
    vt[7] = '{runs:4'd4,  with_clr:1'b0, mode:0, load:5'd5,  starts:4,  dones:1, rd:4'd4,  code:2'd0};
    vt[8] = '{runs:4'd3,  with_clr:1'b0, mode:2, load:5'd19, starts:3,  dones:1, rd:4'd3,  code:2'd0};

    rst = 1'b0; go = 2'b00; runs = 4'd0; clr = 1'b0;
    c_mode[0] = 0; c_mode[1] = 0; c_load[0] = 5'd31; c_load[1] = 5'd31;
    #1;
    check("reset_dut0", {22'd0, outs(0)}, 32'd0);
    check("reset_dut1", {22'd0, outs(1)}, 32'd0);
    skip(2);
    rst = 1'b1;
    skip(2);

    for (int k = 0; k < 9; k++) begin
      c_mode[0] = vt[k].mode;
      c_load[0] = vt[k].load;
      runs = vt[k].runs;
      clr = vt[k].with_clr;
      go[0] = 1'b1;
      nst = 0; ndn = 0;
      for (int c = 0; c < 200; c++) begin
        @(negedge clk);
        go[0] = 1'b0;
        clr = 1'b0;
        nst += int'(cs[0]);
        ndn += int'(dn[0]);
      end
      check($sformatf("vec%0d", k),
            {8'(nst), 8'(ndn), rd0, er[0], code0, bz[0]},
            {8'(vt[k].starts), 8'(vt[k].dones), vt[k].rd, vt[k].code != 2'd0, vt[k].code, 1'b0});
      if (vt[k].code != 2'd0) begin
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        check($sformatf("vec%0d_clr", k), {er[0], code0, bz[0], rd0}, {4'b0000, vt[k].rd});
      end
      wait_idle(0);
    end

    // runs=0: done exactly one cycle after go, nothing launched
    runs = 4'd0; go[0] = 1'b1;
    @(negedge clk); go[0] = 1'b0;
    check("zero_c1", {cs[0], bz[0], dn[0]}, 3'b001);
    @(negedge clk);
    check("zero_c2", dn[0], 1'b0);

    // counter never acknowledges: error code 1 after ACK_MAX wait cycles
    c_mode[0] = 1; runs = 4'd1; go[0] = 1'b1;
    @(negedge clk); go[0] = 1'b0;
    check("ack_c1", {cs[0], bz[0]}, 2'b11);
    skip(2);
    check("ack_c3", er[0], 1'b0);
    skip(1);
    check("ack_c4", {er[0], code0, bz[0], cs[0]}, 5'b10100);
    clr = 1'b1; @(negedge clk); clr = 1'b0;
    check("ack_clr", {er[0], code0, bz[0]}, 4'b0000);
    wait_idle(0);

    // counter skips 20->18: error code 2 on the skip, no relaunch while in error
    c_mode[0] = 2; c_load[0] = 5'd31; runs = 4'd2; go[0] = 1'b1;
    @(negedge clk); go[0] = 1'b0;
    skip(13);
    check("skip_c14", er[0], 1'b0);
    skip(1);
    check("skip_c15", {er[0], code0}, 3'b110);
    skip(5);
    check("skip_hold", {cs[0], er[0], bz[0]}, 3'b010);
    clr = 1'b1; @(negedge clk); clr = 1'b0;
    wait_idle(0);

    // go held high across done: ignored on the done cycle, accepted on the next
    c_mode[0] = 0; c_load[0] = 5'd2; runs = 4'd1; go[0] = 1'b1;
    @(negedge clk);
    skip(4);
    check("hold_c5_done", {dn[0], rd0}, 5'b10001);
    skip(1);
    check("hold_c6_idle", {cs[0], bz[0], dn[0]}, 3'b000);
    skip(1);
    check("hold_c7_start", {cs[0], bz[0]}, 2'b11);
    go[0] = 1'b0; clr = 1'b1; @(negedge clk); clr = 1'b0;
    wait_idle(0);

    // short watchdog: a 31-step countdown times out in its tenth cycle
    c_mode[1] = 0; c_load[1] = 5'd31; runs = 4'd1; go[1] = 1'b1;
    @(negedge clk); go[1] = 1'b0;
    skip(TMO - 1);
    check("tmo_c10", {bz[1], er[1]}, 2'b10);
    skip(1);
    check("tmo_c11", {er[1], code1, bz[1]}, 4'b1110);
    clr = 1'b1; @(negedge clk); clr = 1'b0;
    wait_idle(1);

    // reset in the middle of the second of three runs
    c_load[0] = 5'd31; runs = 4'd3; go[0] = 1'b1;
    @(negedge clk); go[0] = 1'b0;
    skip(44);
    check("rst_pre", {bz[0], rd0}, 5'b10001);
    rst = 1'b0;
    #1;
    check("rst_async", {22'd0, outs(0)}, 32'd0);
    @(negedge clk); rst = 1'b1;
    ndn = 0; nbz = 0;
    for (int c = 0; c < 120; c++) begin
      @(negedge clk);
      ndn += int'(dn[0]);
      nbz += int'(bz[0]);
    end
    check("rst_after", {8'(ndn), 8'(nbz), rd0}, 20'd0);

    // random commands (with occasional clr abort) on the short-watchdog instance
    for (int it = 0; it < 60; it++) begin
      L = $urandom_range(1, 12);
      n = $urandom_range(0, 4);
      abort = ($urandom_range(0, 3) == 0);
      m = $urandom_range(1, 36);
      c_mode[1] = 0;
      c_load[1] = 5'(L);
      wait_idle(1);
      P = L + 2;
      tmo = (n != 0) && (P >= TMO);
      last = (n == 0) ? 3 : (tmo ? TMO + 3 : n * P + 3);
      runs = 4'(n);
      go[1] = 1'b1;
      rd_m = 4'd0;
      for (int c = 1; c <= last; c++) begin
        @(negedge clk);
        go[1] = 1'b0;
        clr = 1'b0;
        ex = expect_at(c, n, P, tmo);
        if (abort && c > m) ex = {6'd0, rd_m};
        check($sformatf("rand%0d_c%0d", it, c), {22'd0, outs(1)}, {22'd0, ex});
        if (abort && c == m) begin
          clr = 1'b1;
          rd_m = ex[3:0];
        end
      end
      clr = 1'b1;
      @(negedge clk);
      clr = 1'b0;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
